player_bullet: RTL and testbench

//  Single player shot: latches a fire press, spawns the bullet centred on the

---
 rtl/player_bullet.sv | 118 +++++++++++
 tb/tb_player_bullet.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_bullet.sv
// Player shot: latches a fire press, launches from the cannon on a frame tick,
// climbs SPEED px per frame, retires on hit or screen top, then cools down.
module player_bullet #(
  parameter int unsigned BULLET_W        = 2,
  parameter int unsigned BULLET_H        = 8,
  parameter int unsigned SPAWN_OFFSET    = 7,
  parameter int unsigned SPAWN_Y         = 432,
  parameter int unsigned SPEED           = 6,
  parameter int unsigned COOLDOWN_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       v_sync,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       fire,
  input  logic [9:0] ship_x_pos,
  input  logic       hit,
  output logic       bullet_active,
  output logic [9:0] bullet_x,
  output logic [9:0] bullet_y,
  output logic       bullet_on
);

  localparam int unsigned CD_W = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
  localparam logic [10:0] X_MAX = 11'(640 - BULLET_W);

  typedef enum logic [1:0] {
    IDLE,
    FLYING,
    COOLDOWN
  } state_t;

  state_t          state;
  logic            vs_prev;
  logic            fire_prev;
  logic            fire_req;
  logic [CD_W-1:0] cd_cnt;

  logic            frame_tick;
  logic            fire_rise;
  logic [10:0]     spawn_sum;
  logic [10:0]     spawn_x;

  assign frame_tick = v_sync & ~vs_prev;
  assign fire_rise  = fire & ~fire_prev;

  // Spawn x computed in 11 bits so a ship near the right edge cannot wrap.
  assign spawn_sum  = {1'b0, ship_x_pos} + 11'(SPAWN_OFFSET);
  assign spawn_x    = (spawn_sum > X_MAX) ? X_MAX : spawn_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      vs_prev       <= 1'b0;
      fire_prev     <= 1'b0;
      fire_req      <= 1'b0;
      cd_cnt        <= '0;
      bullet_active <= 1'b0;
      bullet_x      <= '0;
      bullet_y      <= 10'(SPAWN_Y);
    end else begin
      vs_prev   <= v_sync;
      fire_prev <= fire;
      unique case (state)
        IDLE: begin
          if (frame_tick && fire_req) begin
            state         <= FLYING;
            bullet_active <= 1'b1;
            bullet_x      <= spawn_x[9:0];
            bullet_y      <= 10'(SPAWN_Y);
            fire_req      <= 1'b0;
          end else if (fire_rise) begin
            fire_req <= 1'b1;
          end
        end
        FLYING: begin
          if (hit) begin
            state         <= COOLDOWN;
            bullet_active <= 1'b0;
            cd_cnt        <= CD_W'(COOLDOWN_FRAMES - 1);
          end else if (frame_tick) begin
            if ({1'b0, bullet_y} < 11'(SPEED)) begin
              state         <= COOLDOWN;
              bullet_active <= 1'b0;
              cd_cnt        <= CD_W'(COOLDOWN_FRAMES - 1);
            end else begin
              bullet_y <= bullet_y - 10'(SPEED);
            end
          end
        end
        COOLDOWN: begin
          if (frame_tick) begin
            if (cd_cnt == '0) begin
              state <= IDLE;
            end else begin
              cd_cnt <= cd_cnt - CD_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [10:0] px, py, bx, by;

  always_comb begin
    px        = {1'b0, pix_x};
    py        = {1'b0, pix_y};
    bx        = {1'b0, bullet_x};
    by        = {1'b0, bullet_y};
    bullet_on = bullet_active
              && (px >= bx) && (px < bx + 11'(BULLET_W))
              && (py >= by) && (py < by + 11'(BULLET_H));
  end

endmodule

// File: tb/tb_player_bullet.sv
// Scoreboard bench for player_bullet: a frame-level reference model pushes the
// expected outputs per clock, and an independent monitor pops and compares them.
module tb_player_bullet;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       v_sync = 1'b0;
  logic       fire = 1'b0;
  logic       hit = 1'b0;
  logic [9:0] pix_x = '0;
  logic [9:0] pix_y = '0;
  logic [9:0] ship_x_pos = '0;
  logic       bullet_active;
  logic       bullet_on;
  logic [9:0] bullet_x;
  logic [9:0] bullet_y;

  always #5 clk = ~clk;

  player_bullet #(
    .BULLET_W(2), .BULLET_H(8), .SPAWN_OFFSET(7),
    .SPAWN_Y(432), .SPEED(6), .COOLDOWN_FRAMES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .v_sync(v_sync), .pix_x(pix_x), .pix_y(pix_y),
    .fire(fire), .ship_x_pos(ship_x_pos), .hit(hit),
    .bullet_active(bullet_active), .bullet_x(bullet_x), .bullet_y(bullet_y),
    .bullet_on(bullet_on)
  );

  typedef struct packed {
    logic       act;
    logic [9:0] x;
    logic [9:0] y;
    logic       on;
  } exp_t;

  exp_t sbq[$];
  int   n_pass = 0;
  int   n_total = 0;

  // Reference model: mode 0 idle, 1 flying, 2 cooling; height tracked as frames flown.
  int m_mode, m_x, m_frames, m_cd_left;
  bit m_req, m_lv, m_lf;

  function automatic int m_y();
    return 432 - 6 * m_frames;
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_x = 0; m_frames = 0; m_cd_left = 0;
    m_req = 0; m_lv = 0; m_lf = 0;
  endfunction

  function automatic void model_step(input bit v, input bit f, input int sx, input bit h);
    bit tick, rise;
    tick = v && !m_lv;
    rise = f && !m_lf;
    case (m_mode)
      0: begin
        if (tick && m_req) begin
          m_mode = 1; m_frames = 0; m_req = 0;
          m_x = (sx + 7 > 638) ? 638 : sx + 7;
        end else if (rise) m_req = 1;
      end
      1: begin
        if (h) begin
          m_mode = 2; m_cd_left = 8;
        end else if (tick) begin
          if (m_y() < 6) begin m_mode = 2; m_cd_left = 8; end
          else m_frames++;
        end
      end
      default: begin
        if (tick) begin
          m_cd_left--;
          if (m_cd_left == 0) m_mode = 0;
        end
      end
    endcase
    m_lv = v; m_lf = f;
  endfunction

  function automatic exp_t model_out(input int px, input int py);
    exp_t e;
    e.act = (m_mode == 1);
    e.x   = 10'(m_x);
    e.y   = 10'(m_y());
    e.on  = (m_mode == 1) && px >= m_x && px < m_x + 2 && py >= m_y() && py < m_y() + 8;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  // One clock of stimulus; the model advances with the DUT's posedge.
  task automatic cyc(input bit v, input bit f, input int sx, input bit h, input int px, input int py);
    @(negedge clk);
    v_sync = v; fire = f; ship_x_pos = 10'(sx); hit = h; pix_x = 10'(px); pix_y = 10'(py);
    if (rst_n) model_step(v, f, sx, h);
    else model_reset();
    @(posedge clk);
    #1;
    sbq.push_back(model_out(px, py));
  endtask

  task automatic tick(input bit f, input int sx, input bit h);
    cyc(1, f, sx, h, 0, 0);
    cyc(0, f, sx, 0, 0, 0);
  endtask

  task automatic run_until_idle(input string name);
    int guard = 0;
    while (m_mode != 0 && guard < 200) begin tick(0, 100, 0); guard++; end
    chk(name, guard < 200, 1);
    cyc(0, 0, 100, 0, 0, 0);
  endtask

  // Monitor: compares one expectation per clock, sampled 2 time units after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        n_total++;
        if (bullet_active === e.act && bullet_x === e.x && bullet_y === e.y && bullet_on === e.on)
          n_pass++;
        else
          $display("FAIL sb t=%0t: act/x/y/on got %b/%0d/%0d/%b expected %b/%0d/%0d/%b",
                   $time, bullet_active, bullet_x, bullet_y, bullet_on, e.act, e.x, e.y, e.on);
      end
    end
  end

  initial begin
    int rises, onc;
    bit prev_act;
    model_reset();

    // Reset state
    repeat (3) cyc(0, 0, 0, 0, 0, 432);
    chk("reset_active", bullet_active, 0);
    chk("reset_y", bullet_y, 432);
    @(negedge clk); rst_n = 1'b1;

    // 1: launch centred on cannon, then climb
    cyc(0, 0, 312, 0, 0, 0);
    cyc(0, 1, 312, 0, 0, 0);
    cyc(1, 1, 312, 0, 319, 432);
    chk("launch_active", bullet_active, 1);
    chk("launch_x", bullet_x, 319);
    chk("launch_y", bullet_y, 432);
    cyc(0, 0, 312, 0, 0, 0);
    repeat (3) tick(0, 200, 0);
    chk("climb_y", bullet_y, 414);

    // 2: off the top, fire edges during cooldown ignored, then relaunch
    begin
      int g = 0;
      while (m_mode == 1 && g < 100) begin tick(0, 0, 0); g++; end
      chk("retire_top_bound", g < 100, 1);
    end
    chk("retired_active", bullet_active, 0);
    repeat (7) begin cyc(1, 1, 50, 0, 0, 0); cyc(0, 0, 50, 0, 0, 0); end
    chk("cooldown_active", bullet_active, 0);
    tick(0, 50, 0);
    tick(0, 50, 0);
    chk("no_queued_shot", bullet_active, 0);
    cyc(0, 1, 50, 0, 0, 0);
    tick(0, 50, 0);
    chk("relaunch_active", bullet_active, 1);
    chk("relaunch_x", bullet_x, 57);

    // 3: hit coincident with frame tick at y=300
    run_until_idle("idle_before_hit");
    cyc(0, 1, 400, 0, 0, 0);
    tick(0, 400, 0);
    repeat (22) tick(0, 400, 0);
    chk("pre_hit_y", bullet_y, 300);
    cyc(1, 0, 400, 1, 0, 0);
    chk("hit_active", bullet_active, 0);
    chk("hit_y_hold", bullet_y, 300);
    cyc(0, 0, 400, 0, 0, 0);

    // 4: fire held for 200 frames gives one shot
    run_until_idle("idle_before_hold");
    rises = 0; prev_act = 0;
    cyc(0, 1, 200, 0, 0, 0);
    repeat (200) begin
      tick(1, 200, 0);
      if (bullet_active && !prev_act) rises++;
      prev_act = bullet_active;
    end
    chk("held_fire_launches", rises, 1);
    run_until_idle("idle_after_hold");
    cyc(0, 1, 200, 0, 0, 0);
    tick(0, 200, 0);
    chk("second_launch", bullet_active, 1);

    // 5: right-edge clamp and pixel window
    run_until_idle("idle_before_clamp");
    cyc(0, 1, 636, 0, 0, 0);
    tick(0, 636, 0);
    chk("clamp_x", bullet_x, 638);
    onc = 0;
    for (int py = 430; py <= 441; py++)
      for (int px = 636; px <= 641; px++) begin
        cyc(0, 0, 636, 0, px, py);
        if (bullet_on) onc++;
      end
    chk("on_pixel_count", onc, 16);

    // 6: asynchronous reset mid-flight
    run_until_idle("idle_before_reset");
    cyc(0, 1, 300, 0, 0, 0);
    tick(0, 300, 0);
    repeat (38) tick(0, 300, 0);
    chk("pre_reset_y", bullet_y, 204);
    @(negedge clk); #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_active", bullet_active, 0);
    chk("async_y", bullet_y, 432);
    chk("async_x", bullet_x, 0);
    repeat (2) cyc(0, 0, 300, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    tick(0, 300, 0);
    tick(0, 300, 0);
    chk("no_launch_after_reset", bullet_active, 0);

    // Random phase against the model
    for (int i = 0; i < 2500; i++) begin
      bit v, f, h;
      int sx, px, py;
      v  = ($urandom_range(0, 3) == 0);
      f  = ($urandom_range(0, 4) == 0) ? !fire : fire;
      h  = ($urandom_range(0, 24) == 0);
      sx = $urandom_range(0, 1023);
      px = m_x + $urandom_range(0, 4) - 1;
      py = m_y() + $urandom_range(0, 12) - 2;
      if (px < 0) px = 0;
      if (py < 0) py = 0;
      if (px > 1023) px = 1023;
      if (py > 1023) py = 1023;
      cyc(v, f, sx, h, px, py);
    end

    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
